mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised N-channel arbiter that merges several core-side memory requesters onto one external memory port. Typical requesters are the instruction prefetch bus, the load/store data bus, and any later DMA or debug master. It replaces the fixed split instruction/data ports at the top level so that a single-ported memory can be shared. It supports fixed-priority or round-robin arbitration, plus a lock mode for atomic read-modify-write sequences.

## Interface
Parameters:
- NUM_CHANNELS, 2: number of requesting channels (2..8); channel 0 is highest priority in fixed mode.
- ADDR_WIDTH, 19: word address width, matching the [19:1] bus addressing.
- DATA_WIDTH, 16: data width; BYTESEL_WIDTH = DATA_WIDTH/8.
- ROUND_ROBIN, 1: 1 = round-robin arbitration, 0 = fixed priority.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- c_m_access  in  NUM_CHANNELS  per-channel request; held until that channel's ack.
- c_m_addr  in  NUM_CHANNELS*ADDR_WIDTH  packed per-channel address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- c_m_data_out  in  NUM_CHANNELS*DATA_WIDTH  packed per-channel write data.
- c_m_wr_en  in  NUM_CHANNELS  per-channel write enable.
- c_m_bytesel  in  NUM_CHANNELS*BYTESEL_WIDTH  packed per-channel byte selects.
- c_m_lock  in  NUM_CHANNELS  per-channel lock request (keep the grant after ack).
- c_m_ack  out  NUM_CHANNELS  per-channel ack; one-hot or zero.
- c_m_data_in  out  DATA_WIDTH  read data, broadcast to all channels.
- m_access  out  1  downstream request.
- m_addr  out  ADDR_WIDTH  downstream address.
- m_data_out  out  DATA_WIDTH  downstream write data.
- m_wr_en  out  1  downstream write enable.
- m_bytesel  out  BYTESEL_WIDTH  downstream byte selects.
- m_ack  in  1  downstream ack; a single-cycle pulse.
- m_data_in  in  DATA_WIDTH  downstream read data.
- grant  out  $clog2(NUM_CHANNELS) (min 1)  index of the current or last granted channel.
- grant_valid  out  1  high while in the BUSY or LOCKED state.

## Operation
State machine:
- States are IDLE, BUSY and LOCKED.
- IDLE: build the eligible set = c_m_access & ~served_mask.
  - If the set is non-empty, register the winner into grant and go to BUSY.
- BUSY: m_access = 1. The m_addr, m_data_out, m_wr_en and m_bytesel outputs mux the live inputs of channel grant.
  - On m_ack: if c_m_lock[grant] = 1, go to LOCKED; otherwise go to IDLE, set served_mask = one-hot(grant), and update the priority pointer.
- LOCKED: no other channel can win.
  - If c_m_access[grant] = 1, go to BUSY with the same grant.
  - If c_m_access[grant] = 0 and c_m_lock[grant] = 0, go to IDLE.
  - If c_m_lock[grant] = 1 and c_m_access[grant] = 0, stay in LOCKED.

Arbitration:
- Round-robin: search starts at ptr and wraps modulo NUM_CHANNELS; the first eligible channel wins. On completion, ptr = grant+1, and it wraps from NUM_CHANNELS-1 to 0.
- Fixed: the lowest-indexed eligible channel wins; ptr is unused.
- served_mask lasts exactly one IDLE cycle, then clears. This prevents a channel whose access is still high in the cycle after its ack from being re-granted as a spurious second access.

Acks and data:
- c_m_ack[i] = m_ack & (state == BUSY) & (grant == i). This is combinational passthrough.
- c_m_data_in = m_data_in, unregistered.
- m_ack received outside BUSY is ignored.

Protocol rule:
- A channel must not drop access or change its address or data before its ack. If it does, the arbiter still holds BUSY and m_access until m_ack.

Reset (reset = 0 at a clock edge):
- state = IDLE, grant = 0, ptr = 0, served_mask = 0.
- m_access = 0, grant_valid = 0, c_m_ack = 0.
- Reset overrides any in-flight transaction; a late m_ack is then ignored.

## Timing
- Arbitration latency: a request seen in IDLE in cycle n gives m_access = 1 in cycle n+1.
- Ack latency: zero; c_m_ack is high in the same cycle as m_ack.
- Turnaround: after an unlocked ack there is one IDLE cycle before the next grant, so back-to-back accesses have a throughput of one transaction per (downstream latency + 2) cycles.
- Locked turnaround: after a locked ack there is one LOCKED cycle, then BUSY again if access is still high.
- Simultaneous events:
  - A new request arriving in the same cycle as m_ack is considered in the following IDLE cycle.
  - Lock released in the same cycle as m_ack: LOCKED is not entered.

## Test plan
- Single request: NUM_CHANNELS=2, c_m_access=01, addr 0x12345, downstream acks 2 cycles after m_access → m_access high for 3 cycles, m_addr=0x12345, c_m_ack=01 for one cycle, grant_valid falls the next cycle.
- Round-robin fairness: NUM_CHANNELS=4, all four channels requesting continuously, zero-wait downstream → grant sequence 0,1,2,3,0; the served channel is never re-granted in its turnaround cycle.
- Fixed priority: ROUND_ROBIN=0, channels 0 and 1 both requesting continuously → channel 1 is granted only during channel 0's served_mask cycle, so the grants alternate 0,1,0,1.
- Lock mode: channel 1 asserts c_m_lock for a read then a write while channel 0 is requesting → both channel-1 transactions complete before channel 0 gets any grant, and channel 0 is granted after the lock drops.
- Reset mid-transaction: reset=0 while in BUSY, then m_ack arrives 2 cycles later → m_access=0 the cycle after reset, and no c_m_ack bit asserts.
- Width and data: DATA_WIDTH=32, write from channel 2 with bytesel=4'b0110 → m_bytesel=0110, and m_data_out equals channel 2's data during BUSY.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Merges NUM_CHANNELS core-side memory requesters onto one external port.
// Fixed-priority or round-robin selection, with a lock that holds the grant across accesses.
module mem_bus_arbiter #(
   parameter int NUM_CHANNELS   = 2,
   parameter int ADDR_WIDTH     = 19,
   parameter int DATA_WIDTH     = 16,
   parameter int ROUND_ROBIN    = 1,
   localparam int BYTESEL_WIDTH = DATA_WIDTH / 8,
   localparam int GW            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CHANNELS-1:0]                 c_m_access,
   input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]      c_m_addr,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      c_m_data_out,
   input  logic [NUM_CHANNELS-1:0]                 c_m_wr_en,
   input  logic [NUM_CHANNELS*BYTESEL_WIDTH-1:0]   c_m_bytesel,
   input  logic [NUM_CHANNELS-1:0]                 c_m_lock,
   output logic [NUM_CHANNELS-1:0]                 c_m_ack,
   output logic [DATA_WIDTH-1:0]                   c_m_data_in,
   output logic                                    m_access,
   output logic [ADDR_WIDTH-1:0]                   m_addr,
   output logic [DATA_WIDTH-1:0]                   m_data_out,
   output logic                                    m_wr_en,
   output logic [BYTESEL_WIDTH-1:0]                m_bytesel,
   input  logic                                    m_ack,
   input  logic [DATA_WIDTH-1:0]                   m_data_in,
   output logic [GW-1:0]                           grant,
   output logic                                    grant_valid
);

   typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]    addr;
      logic [DATA_WIDTH-1:0]    data;
      logic                     wr_en;
      logic [BYTESEL_WIDTH-1:0] bytesel;
   } req_t;

   state_t                        state, state_d;
   logic [GW-1:0]                 grant_d, ptr, ptr_d, winner;
   logic [NUM_CHANNELS-1:0]       served_mask, served_d, elig;
   req_t [NUM_CHANNELS-1:0]       req;
   req_t                          bus_req;
   int                            rank, best;

   generate
      for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
         assign req[i] = '{addr:    c_m_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                           data:    c_m_data_out[i*DATA_WIDTH +: DATA_WIDTH],
                           wr_en:   c_m_wr_en[i],
                           bytesel: c_m_bytesel[i*BYTESEL_WIDTH +: BYTESEL_WIDTH]};
         assign c_m_ack[i] = m_ack && (state == BUSY) && (grant == GW'(i));
      end
   endgenerate

   // Winner = eligible channel with the smallest rank; rank is the distance
   // from ptr in round-robin mode and the plain index in fixed mode.
   always_comb begin
      elig   = c_m_access & ~served_mask;
      winner = '0;
      best   = NUM_CHANNELS;
      rank   = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         rank = (ROUND_ROBIN != 0) ? (i + NUM_CHANNELS - int'(ptr)) % NUM_CHANNELS : i;
         if (elig[i] && rank < best) begin
            best   = rank;
            winner = GW'(i);
         end
      end
   end

   always_comb begin
      bus_req = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (grant == GW'(i)) bus_req = req[i];
   end

   always_comb begin
      state_d  = state;
      grant_d  = grant;
      ptr_d    = ptr;
      served_d = served_mask;
      case (state)
         IDLE: begin
            served_d = '0;
            if (|elig) begin
               state_d = BUSY;
               grant_d = winner;
            end
         end
         BUSY: begin
            if (m_ack) begin
               if (c_m_lock[grant]) begin
                  state_d = LOCKED;
               end else begin
                  // Mask the served channel for one IDLE cycle so a late-dropping access is not re-granted
                  state_d         = IDLE;
                  served_d        = '0;
                  served_d[grant] = 1'b1;
                  ptr_d           = (grant == GW'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
               end
            end
         end
         LOCKED: begin
            if (c_m_access[grant])     state_d = BUSY;
            else if (!c_m_lock[grant]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         ptr         <= '0;
         served_mask <= '0;
      end else begin
         state       <= state_d;
         grant       <= grant_d;
         ptr         <= ptr_d;
         served_mask <= served_d;
      end
   end

   assign m_access    = (state == BUSY);
   assign grant_valid = (state != IDLE);
   assign m_addr      = bus_req.addr;
   assign m_data_out  = bus_req.data;
   assign m_wr_en     = bus_req.wr_en;
   assign m_bytesel   = bus_req.bytesel;
   assign c_m_data_in = m_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Instance a: 4 channels, 32-bit data, round-robin. Instance b: 2 channels, 16-bit data, fixed priority.
module tb_mem_bus_arbiter;
   localparam int AW = 19;
   localparam int NA = 4, DWA = 32, BWA = 4, GWA = 2;
   localparam int NB = 2, DWB = 16, BWB = 2, GWB = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [NA-1:0]     a_acc, a_wr, a_lock, a_ack;
   logic [NA*AW-1:0]  a_addr;
   logic [NA*DWA-1:0] a_dout;
   logic [NA*BWA-1:0] a_bs;
   logic [DWA-1:0]    a_cdin, a_mdout, a_mdin;
   logic              a_macc, a_mwr, a_mack, a_gv;
   logic [AW-1:0]     a_maddr;
   logic [BWA-1:0]    a_mbs;
   logic [GWA-1:0]    a_grant;

   logic [NB-1:0]     b_acc, b_wr, b_lock, b_ack;
   logic [NB*AW-1:0]  b_addr;
   logic [NB*DWB-1:0] b_dout;
   logic [NB*BWB-1:0] b_bs;
   logic [DWB-1:0]    b_cdin, b_mdout, b_mdin;
   logic              b_macc, b_mwr, b_mack, b_gv;
   logic [AW-1:0]     b_maddr;
   logic [BWB-1:0]    b_mbs;
   logic [GWB-1:0]    b_grant;

   mem_bus_arbiter #(.NUM_CHANNELS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DWA), .ROUND_ROBIN(1)) u_a (
      .clk(clk), .reset(reset),
      .c_m_access(a_acc), .c_m_addr(a_addr), .c_m_data_out(a_dout), .c_m_wr_en(a_wr),
      .c_m_bytesel(a_bs), .c_m_lock(a_lock), .c_m_ack(a_ack), .c_m_data_in(a_cdin),
      .m_access(a_macc), .m_addr(a_maddr), .m_data_out(a_mdout), .m_wr_en(a_mwr),
      .m_bytesel(a_mbs), .m_ack(a_mack), .m_data_in(a_mdin),
      .grant(a_grant), .grant_valid(a_gv));

   mem_bus_arbiter #(.NUM_CHANNELS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DWB), .ROUND_ROBIN(0)) u_b (
      .clk(clk), .reset(reset),
      .c_m_access(b_acc), .c_m_addr(b_addr), .c_m_data_out(b_dout), .c_m_wr_en(b_wr),
      .c_m_bytesel(b_bs), .c_m_lock(b_lock), .c_m_ack(b_ack), .c_m_data_in(b_cdin),
      .m_access(b_macc), .m_addr(b_maddr), .m_data_out(b_mdout), .m_wr_en(b_mwr),
      .m_bytesel(b_mbs), .m_ack(b_mack), .m_data_in(b_mdin),
      .grant(b_grant), .grant_valid(b_gv));

   task automatic clr_inputs();
      a_acc = '0; a_wr = '0; a_lock = '0; a_addr = '0; a_dout = '0; a_bs = '0; a_mack = 1'b0; a_mdin = '0;
      b_acc = '0; b_wr = '0; b_lock = '0; b_addr = '0; b_dout = '0; b_bs = '0; b_mack = 1'b0; b_mdin = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clr_inputs();
      reset = 1'b0;
      a_acc = '1; b_acc = '1; a_mack = 1'b1; b_mack = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         checks++; if ({a_macc, a_gv, a_grant} !== '0) begin errors++; $display("FAIL rst_a_state: got %b exp 0", {a_macc, a_gv, a_grant}); end
         checks++; if (a_ack !== '0) begin errors++; $display("FAIL rst_a_ack: got %b exp 0000", a_ack); end
         checks++; if ({b_macc, b_gv, b_grant, b_ack} !== '0) begin errors++; $display("FAIL rst_b: got %b exp 0", {b_macc, b_gv, b_grant, b_ack}); end
      end
      @(negedge clk);
      reset = 1'b1;
      clr_inputs();
   endtask

   task automatic test_single();
      logic [DWB-1:0] d;
      do_reset();
      @(negedge clk);
      b_acc = 2'b01;
      b_addr[0 +: AW] = 19'h12345;
      b_addr[AW +: AW] = 19'h7abcd;
      #1;
      checks++; if (b_macc !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", b_macc); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         b_mack = (c == 3);
         d = DWB'($urandom);
         b_mdin = d;
         #1;
         checks++; if ({b_macc, b_gv, b_grant} !== 3'b110) begin errors++; $display("FAIL single_busy%0d: got %b exp 110", c, {b_macc, b_gv, b_grant}); end
         checks++; if (b_maddr !== 19'h12345) begin errors++; $display("FAIL single_addr%0d: got %h exp 12345", c, b_maddr); end
         checks++; if (b_ack !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_ack%0d: got %b", c, b_ack); end
         checks++; if (b_cdin !== d) begin errors++; $display("FAIL single_rdata%0d: got %h exp %h", c, b_cdin, d); end
      end
      @(negedge clk);
      b_mack = 1'b0; b_acc = '0;
      #1;
      checks++; if ({b_macc, b_gv, b_ack} !== 4'b0000) begin errors++; $display("FAIL single_done: got %b exp 0000", {b_macc, b_gv, b_ack}); end
      @(negedge clk);
      b_mack = 1'b1;
      #1;
      checks++; if (b_ack !== 2'b00) begin errors++; $display("FAIL stray_ack: got %b exp 00", b_ack); end
      @(negedge clk);
      b_mack = 1'b0;
      #1;
      checks++; if (b_macc !== 1'b0) begin errors++; $display("FAIL stray_ack_idle: got %b exp 0", b_macc); end
   endtask

   task automatic test_rr_fair();
      int exp_g, n;
      logic [NA-1:0] oh;
      do_reset();
      exp_g = 0; n = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         a_acc = '1;
         a_mack = a_macc;
         #1;
         if (a_macc) begin
            oh = '0; oh[exp_g] = 1'b1;
            checks++; if (a_grant !== GWA'(exp_g)) begin errors++; $display("FAIL rr_grant: got %0d exp %0d", a_grant, exp_g); end
            checks++; if (a_ack !== oh) begin errors++; $display("FAIL rr_ack: got %b exp %b", a_ack, oh); end
            exp_g = (exp_g + 1) % NA;
            n++;
         end else begin
            checks++; if ({a_gv, a_ack} !== '0) begin errors++; $display("FAIL rr_turnaround: got %b exp 0", {a_gv, a_ack}); end
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL rr_throughput: got %0d grants exp 8", n); end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_fixed();
      int n;
      logic [NB-1:0] oh;
      do_reset();
      @(negedge clk);
      b_acc = 2'b01;
      #1;
      @(negedge clk);
      b_mack = 1'b1;
      #1;
      checks++; if (b_ack !== 2'b01) begin errors++; $display("FAIL fix_first_ack: got %b exp 01", b_ack); end
      @(negedge clk);
      b_mack = 1'b0; b_acc = 2'b00;
      #1;
      @(negedge clk);
      b_acc = 2'b11;
      #1;
      n = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         b_mack = b_macc;
         #1;
         if (b_macc) begin
            oh = '0; oh[n % 2] = 1'b1;
            checks++; if (b_grant !== GWB'(n % 2)) begin errors++; $display("FAIL fix_grant%0d: got %0d exp %0d", n, b_grant, n % 2); end
            checks++; if (b_ack !== oh) begin errors++; $display("FAIL fix_ack%0d: got %b exp %b", n, b_ack, oh); end
            n++;
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL fix_count: got %0d exp 8", n); end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_lock();
      logic [AW-1:0]  a0, a1, a1b;
      logic [DWB-1:0] d1;
      do_reset();
      a0 = AW'($urandom); a1 = AW'($urandom); a1b = AW'($urandom); d1 = DWB'($urandom);
      @(negedge clk);
      b_acc = 2'b10; b_lock = 2'b10; b_addr = {a1, a0}; b_wr = 2'b00;
      #1;
      checks++; if (b_macc !== 1'b0) begin errors++; $display("FAIL lock_idle: got %b exp 0", b_macc); end
      @(negedge clk);
      b_acc = 2'b11; b_mack = 1'b1;
      #1;
      checks++; if ({b_macc, b_grant, b_ack} !== 4'b1110) begin errors++; $display("FAIL lock_rd: got %b exp 1110", {b_macc, b_grant, b_ack}); end
      checks++; if (b_maddr !== a1) begin errors++; $display("FAIL lock_rd_addr: got %h exp %h", b_maddr, a1); end
      @(negedge clk);
      b_mack = 1'b0; b_acc = 2'b01;
      #1;
      checks++; if ({b_macc, b_gv, b_grant, b_ack} !== 5'b01100) begin errors++; $display("FAIL lock_hold: got %b exp 01100", {b_macc, b_gv, b_grant, b_ack}); end
      @(negedge clk);
      b_acc = 2'b11; b_wr = 2'b10; b_addr = {a1b, a0}; b_dout = {d1, 16'h0};
      #1;
      checks++; if ({b_macc, b_gv, b_grant} !== 3'b011) begin errors++; $display("FAIL lock_reacq: got %b exp 011", {b_macc, b_gv, b_grant}); end
      @(negedge clk);
      #1;
      checks++; if ({b_macc, b_grant, b_mwr} !== 3'b111) begin errors++; $display("FAIL lock_wr: got %b exp 111", {b_macc, b_grant, b_mwr}); end
      checks++; if ({b_maddr, b_mdout} !== {a1b, d1}) begin errors++; $display("FAIL lock_wr_data: got %h exp %h", {b_maddr, b_mdout}, {a1b, d1}); end
      @(negedge clk);
      b_mack = 1'b1; b_lock = 2'b00;
      #1;
      checks++; if (b_ack !== 2'b10) begin errors++; $display("FAIL lock_wr_ack: got %b exp 10", b_ack); end
      @(negedge clk);
      b_mack = 1'b0; b_acc = 2'b01;
      #1;
      checks++; if ({b_macc, b_gv} !== 2'b00) begin errors++; $display("FAIL lock_release: got %b exp 00", {b_macc, b_gv}); end
      @(negedge clk);
      #1;
      checks++; if ({b_macc, b_grant, b_ack} !== 4'b1000) begin errors++; $display("FAIL lock_ch0: got %b exp 1000", {b_macc, b_grant, b_ack}); end
      checks++; if (b_maddr !== a0) begin errors++; $display("FAIL lock_ch0_addr: got %h exp %h", b_maddr, a0); end
      @(negedge clk);
      b_mack = 1'b1;
      #1;
      checks++; if (b_ack !== 2'b01) begin errors++; $display("FAIL lock_ch0_ack: got %b exp 01", b_ack); end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      a_acc = 4'b0100;
      #1;
      @(negedge clk);
      reset = 1'b0; a_acc = '0;
      #1;
      checks++; if ({a_macc, a_grant} !== 3'b110) begin errors++; $display("FAIL rmid_busy: got %b exp 110", {a_macc, a_grant}); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if ({a_macc, a_gv, a_grant} !== 4'b0000) begin errors++; $display("FAIL rmid_after: got %b exp 0000", {a_macc, a_gv, a_grant}); end
      @(negedge clk);
      a_mack = 1'b1;
      #1;
      checks++; if ({a_ack, a_macc} !== 5'b00000) begin errors++; $display("FAIL rmid_late_ack: got %b exp 00000", {a_ack, a_macc}); end
      @(negedge clk);
      a_mack = 1'b0;
      #1;
      checks++; if (a_macc !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got %b exp 0", a_macc); end
   endtask

   task automatic test_width();
      logic [DWA-1:0] d2;
      logic [AW-1:0]  ad2;
      do_reset();
      @(negedge clk);
      for (int i = 0; i < NA; i++) begin
         a_addr[i*AW +: AW]   = AW'($urandom);
         a_dout[i*DWA +: DWA] = $urandom;
         a_bs[i*BWA +: BWA]   = BWA'($urandom);
      end
      d2 = $urandom; ad2 = AW'($urandom);
      a_addr[2*AW +: AW] = ad2; a_dout[2*DWA +: DWA] = d2; a_bs[2*BWA +: BWA] = 4'b0110;
      a_wr = 4'b0100; a_acc = 4'b0100;
      #1;
      @(negedge clk);
      #1;
      checks++; if ({a_macc, a_grant, a_mwr, a_mbs} !== 8'b1_10_1_0110) begin errors++; $display("FAIL width_ctl: got %b exp 11010110", {a_macc, a_grant, a_mwr, a_mbs}); end
      checks++; if ({a_maddr, a_mdout} !== {ad2, d2}) begin errors++; $display("FAIL width_data: got %h exp %h", {a_maddr, a_mdout}, {ad2, d2}); end
      @(negedge clk);
      a_mack = 1'b1;
      #1;
      checks++; if (a_ack !== 4'b0100) begin errors++; $display("FAIL width_ack: got %b exp 0100", a_ack); end
      @(negedge clk);
      clr_inputs();
   endtask

   // Requesters hold until acked; model tracks one outstanding transaction, the
   // channel served last, and the round-robin start point.
   task automatic test_random();
      logic [AW-1:0]  ad [NA];
      logic [DWA-1:0] dt [NA];
      logic [BWA-1:0] bs [NA];
      logic [NA-1:0]  wr, req, served, elig, exp_ack;
      int acked, g, ptr, lat;
      bit busy, found, exp_acc;
      do_reset();
      req = '0; served = '0; wr = '0; acked = -1; g = 0; ptr = 0; lat = -1; busy = 0;
      for (int i = 0; i < NA; i++) begin ad[i] = '0; dt[i] = '0; bs[i] = '0; end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < NA; i++) begin
            if (i == acked || !req[i]) begin
               if (i == acked) req[i] = 1'($urandom_range(0, 1));
               else            req[i] = ($urandom_range(0, 99) < 30);
               ad[i] = AW'($urandom); dt[i] = $urandom; wr[i] = 1'($urandom_range(0, 1)); bs[i] = BWA'($urandom);
            end
            a_addr[i*AW +: AW] = ad[i]; a_dout[i*DWA +: DWA] = dt[i]; a_bs[i*BWA +: BWA] = bs[i];
         end
         a_acc = req; a_wr = wr; acked = -1;
         if (a_macc) begin
            if (lat < 0) lat = $urandom_range(0, 3);
            a_mack = (lat == 0);
            lat = (lat == 0) ? -1 : lat - 1;
         end else begin
            a_mack = ($urandom_range(0, 9) == 0);
         end
         a_mdin = $urandom;
         #1;
         exp_ack = '0; exp_acc = busy;
         if (!busy) begin
            elig = req & ~served; served = '0; found = 0;
            for (int k = 0; k < NA; k++)
               if (!found && elig[(ptr + k) % NA]) begin found = 1; g = (ptr + k) % NA; end
            busy = found;
         end else begin
            checks++;
            if ({a_grant, a_maddr, a_mdout, a_mwr, a_mbs} !== {GWA'(g), ad[g], dt[g], wr[g], bs[g]}) begin
               errors++; $display("FAIL rnd_bus cyc %0d: got %h exp %h", cyc, {a_grant, a_maddr, a_mdout, a_mwr, a_mbs}, {GWA'(g), ad[g], dt[g], wr[g], bs[g]});
            end
            if (a_mack) begin
               exp_ack[g] = 1'b1; served = '0; served[g] = 1'b1; ptr = (g + 1) % NA; acked = g; busy = 0;
            end
         end
         checks++; if ({a_macc, a_gv} !== {exp_acc, exp_acc}) begin errors++; $display("FAIL rnd_access cyc %0d: got %b exp %b", cyc, {a_macc, a_gv}, {exp_acc, exp_acc}); end
         checks++; if (a_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack cyc %0d: got %b exp %b", cyc, a_ack, exp_ack); end
         checks++; if (a_cdin !== a_mdin) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h exp %h", cyc, a_cdin, a_mdin); end
      end
      @(negedge clk);
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      test_reset();
      test_single();
      test_rr_fair();
      test_fixed();
      test_lock();
      test_reset_mid();
      test_width();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
